// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: valid/ready shift/rotate engine (ROR/ROL/LSR/LSL/ASR) with carry and zero flags.
// SHIFT_ROTATE_PIPELINE_EN: SHW-stage logarithmic barrel (latency SHW); undefined: single-cycle shifter (latency 1).
module shift_rotate_unit #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);
    logic           adv;
    logic           right;
    logic           rsvd;
    logic           carry_in;
    logic [SHW-1:0] idx_r;
    logic [SHW-1:0] idx_l;

    function automatic logic [WIDTH-1:0] sh(input logic [WIDTH-1:0] d, input logic [2:0] op, input logic [SHW-1:0] n);
        logic signed [WIDTH-1:0] a;
        a = $signed(d) >>> n;
        return op == 3'd0 ? (d >> n) | (d << (WIDTH - int'(n))) :
               op == 3'd1 ? (d << n) | (d >> (WIDTH - int'(n))) :
               op == 3'd2 ? d >> n :
               op == 3'd3 ? d << n :
               op == 3'd4 ? a : d;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Carry comes from the original operand at acceptance and rides along with the op.
    always_comb begin
        right    = in_op == 3'd0 || in_op == 3'd2 || in_op == 3'd4;
        rsvd     = in_op > 3'd4;
        idx_r    = in_amt - SHW'(1);
        idx_l    = '0 - in_amt;
        carry_in = (in_amt == '0 || rsvd) ? 1'b0 : right ? in_data[idx_r] : in_data[idx_l];
    end

`ifdef SHIFT_ROTATE_PIPELINE_EN
    logic [SHW-1:0][WIDTH-1:0] dat_d, dat_q;
    logic [SHW-1:0][2:0]       op_d, op_q;
    logic [SHW-1:0][SHW-1:0]   amt_d, amt_q;
    logic [SHW-1:0]            carry_d, carry_q;
    logic [SHW-1:0]            valid_d, valid_q;
    logic                      zero_d, zero_q;

    // Stage k applies a 2^k step when amount bit k is set; all stages move together on adv.
    always_comb begin
        dat_d[0]   = adv ? sh(in_data, in_op, in_amt[0] ? SHW'(1) : '0) : dat_q[0];
        op_d[0]    = adv ? in_op : op_q[0];
        amt_d[0]   = adv ? in_amt : amt_q[0];
        carry_d[0] = adv ? carry_in : carry_q[0];
        valid_d[0] = adv ? in_valid : valid_q[0];
        for (int k = 1; k < SHW; k++) begin
            dat_d[k]   = adv ? sh(dat_q[k-1], op_q[k-1], amt_q[k-1][k] ? SHW'(1 << k) : '0) : dat_q[k];
            op_d[k]    = adv ? op_q[k-1] : op_q[k];
            amt_d[k]   = adv ? amt_q[k-1] : amt_q[k];
            carry_d[k] = adv ? carry_q[k-1] : carry_q[k];
            valid_d[k] = adv ? valid_q[k-1] : valid_q[k];
        end
        zero_d = dat_d[SHW-1] == '0;
    end

    // Pipeline registers; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q   <= '0;
            op_q    <= '0;
            amt_q   <= '0;
            carry_q <= '0;
            valid_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            dat_q   <= dat_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign out_data  = dat_q[SHW-1];
    assign out_carry = carry_q[SHW-1];
    assign out_zero  = zero_q;
`else
    logic [WIDTH-1:0] dat_d, dat_q;
    logic             carry_d, carry_q;
    logic             valid_d, valid_q;
    logic             zero_d, zero_q;

    // Full shift in one cycle, captured in the output register on adv.
    always_comb begin
        dat_d   = adv ? sh(in_data, in_op, in_amt) : dat_q;
        carry_d = adv ? carry_in : carry_q;
        valid_d = adv ? in_valid : valid_q;
        zero_d  = dat_d == '0;
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            dat_q   <= dat_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = dat_q;
    assign out_carry = carry_q;
    assign out_zero  = zero_q;
`endif
endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb_shift_rotate_unit: directed vectors with a queue scoreboard and a negedge output monitor.
module tb_shift_rotate_unit;
    localparam int W = 16;
`ifdef SHIFT_ROTATE_PIPELINE_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [3:0]    in_amt = '0;
    logic [2:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic         z;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           seen = 0;
    logic [W-1:0] hold_d;
    logic         hold_c;
    logic         hold_z;

    shift_rotate_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp_v, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on each newly presented result and checks holds during stalls.
    always @(negedge clk) begin
        if (rst) seen = 0;
        else if (out_valid) begin
            if (!seen) begin
                if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_carry", 32'(out_carry), 32'(e.c));
                    chk("out_zero", 32'(out_zero), 32'(e.z));
                    if (e.lat) chk("latency", 32'(cyc - e.acc + 1), 32'(EXP_LAT));
                end
                hold_d = out_data;
                hold_c = out_carry;
                hold_z = out_zero;
                seen = 1;
            end else begin
                chk("stall_data", 32'(out_data), 32'(hold_d));
                chk("stall_carry", 32'(out_carry), 32'(hold_c));
                chk("stall_zero", 32'(out_zero), 32'(hold_z));
            end
            if (!out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            else seen = 0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] a,
                         input logic [W-1:0] ed, input logic ec, input bit lat);
        bit ok = 0;
        exp_t x;
        in_valid = 1'b1;
        in_op = op;
        in_data = d;
        in_amt = a;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                x.d = ed;
                x.c = ec;
                x.z = (ed == '0);
                x.acc = cyc + 1;
                x.lat = lat;
                q.push_back(x);
                ok = 1;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1 ok = (q.size() == 0);
        end
        if (!ok) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic one(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] a,
                       input logic [W-1:0] ed, input logic ec);
        issue(op, d, a, ed, ec, 1);
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // isolated ops: op, data, amt, expected data, expected carry
        one(3'd0, 16'h8001, 4'd1,  16'hC000, 1'b1);
        one(3'd0, 16'h8001, 4'd0,  16'h8001, 1'b0);
        one(3'd3, 16'h8001, 4'd1,  16'h0002, 1'b1);
        one(3'd2, 16'h0001, 4'd1,  16'h0000, 1'b1);
        one(3'd4, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        one(3'd1, 16'h1234, 4'd4,  16'h2341, 1'b1);
        one(3'd7, 16'hA5A5, 4'd7,  16'hA5A5, 1'b0);
        one(3'd5, 16'h1234, 4'd3,  16'h1234, 1'b0);
        one(3'd4, 16'h8000, 4'd0,  16'h8000, 1'b0);
        one(3'd3, 16'h0001, 4'd15, 16'h8000, 1'b0);
        one(3'd2, 16'h8000, 4'd15, 16'h0001, 1'b0);
        one(3'd1, 16'h8001, 4'd15, 16'hC000, 1'b0);
        one(3'd0, 16'h00F0, 4'd4,  16'h000F, 1'b0);
        one(3'd2, 16'h00F0, 4'd5,  16'h0007, 1'b1);
        one(3'd4, 16'h4000, 4'd3,  16'h0800, 1'b0);
        // five back-to-back ops with a six-cycle stall once results appear
        fork
            begin
                issue(3'd0, 16'h0001, 4'd1, 16'h8000, 1'b1, 0);
                issue(3'd3, 16'h00FF, 4'd8, 16'hFF00, 1'b0, 0);
                issue(3'd4, 16'hF000, 4'd4, 16'hFF00, 1'b0, 0);
                issue(3'd2, 16'hFFFF, 4'd4, 16'h0FFF, 1'b1, 0);
                issue(3'd1, 16'h000F, 4'd4, 16'h00F0, 1'b0, 0);
            end
            begin
                for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        // reset with ops in flight
        issue(3'd0, 16'h1111, 4'd1, 16'h8888, 1'b1, 0);
        issue(3'd3, 16'h2222, 4'd2, 16'h8888, 1'b0, 0);
        issue(3'd2, 16'h3333, 4'd3, 16'h0666, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("post_rst_out_data", 32'(out_data), 32'd0);
        chk("post_rst_out_carry", 32'(out_carry), 32'd0);
        chk("post_rst_out_zero", 32'(out_zero), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        one(3'd0, 16'h0003, 4'd1, 16'h8001, 1'b1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
